// File: rtl/control_fsm.sv
// Multi-cycle CPU control sequencer: fetch, decode/execute, bus wait with timeout,
// fault capture and a retired-instruction counter.
module control_fsm #(
  parameter int TIMEOUT = 255,
  parameter int RET_W   = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  input  logic             fault_clr,
  input  logic             BUS_rdata_valid,
  input  logic             BUS_write_done,
  input  logic             alu_zero,
  input  logic [7:0]       ins_op,
  output logic [2:0]       state,
  output logic             ins_reg_en,
  output logic             reg_wen,
  output logic [1:0]       reg_CS,
  output logic             PC_EN,
  output logic [1:0]       PC_mode,
  output logic             ALU_mode,
  output logic             ALU_CS2,
  output logic             BUS_ADDR_CS,
  output logic             BUS_mode,
  output logic             BUS_start_transaction,
  output logic             fault,
  output logic [1:0]       fault_code,
  output logic [RET_W-1:0] retired
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_IF1   = 3'd1,
    S_IF2   = 3'd2,
    S_EX1   = 3'd3,
    S_EX2   = 3'd4,
    S_EX3   = 3'd5,
    S_FAULT = 3'd7
  } state_t;

  // Counter value seen in the last permitted wait cycle.
  localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT - 1);
  localparam logic [RET_W-1:0] RET_ONE = {{(RET_W-1){1'b0}}, 1'b1};

  state_t           state_reg, state_next;
  logic [15:0]      wait_reg, wait_next;
  logic [1:0]       fault_code_reg, fault_code_next;
  logic             is_sw_reg, is_sw_next;
  logic [RET_W-1:0] retired_reg;
  logic             retire;
  logic             op_onehot;

  assign op_onehot  = (ins_op != 8'd0) && ((ins_op & (ins_op - 8'd1)) == 8'd0);
  assign state      = state_reg;
  assign fault      = (state_reg == S_FAULT);
  assign fault_code = fault_code_reg;
  assign retired    = retired_reg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg      <= S_IDLE;
      wait_reg       <= 16'd0;
      fault_code_reg <= 2'd0;
      is_sw_reg      <= 1'b0;
      retired_reg    <= '0;
    end else begin
      state_reg      <= state_next;
      wait_reg       <= wait_next;
      fault_code_reg <= fault_code_next;
      is_sw_reg      <= is_sw_next;
      if (retire) retired_reg <= retired_reg + RET_ONE;
    end
  end

  always_comb begin
    state_next            = state_reg;
    wait_next             = wait_reg;
    fault_code_next       = fault_code_reg;
    is_sw_next            = is_sw_reg;
    retire                = 1'b0;
    ins_reg_en            = 1'b0;
    reg_wen               = 1'b0;
    reg_CS                = 2'd0;
    PC_EN                 = 1'b0;
    PC_mode               = 2'd0;
    ALU_mode              = 1'b0;
    ALU_CS2               = 1'b0;
    BUS_ADDR_CS           = 1'b0;
    BUS_mode              = 1'b0;
    BUS_start_transaction = 1'b0;

    case (state_reg)
      S_IDLE: if (run) state_next = S_IF1;
      S_IF1: begin
        BUS_start_transaction = 1'b1;
        wait_next             = 16'd0;
        state_next            = S_IF2;
      end
      S_IF2: begin
        if (BUS_rdata_valid) begin
          ins_reg_en = 1'b1;
          PC_EN      = 1'b1;
          wait_next  = 16'd0;
          state_next = S_EX1;
        end else if (wait_reg == WAIT_LAST) begin
          fault_code_next = 2'd1;
          state_next      = S_FAULT;
        end else begin
          wait_next = wait_reg + 16'd1;
        end
      end
      S_EX1: begin
        if (!op_onehot) begin
          fault_code_next = 2'd3;
          state_next      = S_FAULT;
        end else if (ins_op[2] || ins_op[3]) begin
          BUS_start_transaction = 1'b1;
          BUS_ADDR_CS           = 1'b1;
          ALU_CS2               = 1'b1;
          BUS_mode              = ins_op[2];
          is_sw_next            = ins_op[2];
          wait_next             = 16'd0;
          state_next            = S_EX2;
        end else begin
          retire = 1'b1;
          if (ins_op[0] || ins_op[1] || ins_op[4]) begin
            reg_wen  = 1'b1;
            ALU_mode = ins_op[1];
            ALU_CS2  = ins_op[4];
          end else if (ins_op[5]) begin
            reg_wen = 1'b1;
            reg_CS  = 2'd2;
          end else if (ins_op[6]) begin
            reg_wen = 1'b1;
            reg_CS  = 2'd3;
            PC_EN   = 1'b1;
            PC_mode = 2'd1;
          end else begin
            ALU_mode = 1'b1;
            PC_EN    = alu_zero;
            PC_mode  = 2'd2;
          end
        end
      end
      S_EX2: begin
        BUS_ADDR_CS = 1'b1;
        BUS_mode    = is_sw_reg;
        // Only the response matching the pending access counts.
        if (is_sw_reg ? BUS_write_done : BUS_rdata_valid) begin
          if (is_sw_reg) retire = 1'b1;
          else state_next = S_EX3;
        end else if (wait_reg == WAIT_LAST) begin
          fault_code_next = 2'd2;
          state_next      = S_FAULT;
        end else begin
          wait_next = wait_reg + 16'd1;
        end
      end
      S_EX3: begin
        reg_wen = 1'b1;
        reg_CS  = 2'd1;
        retire  = 1'b1;
      end
      S_FAULT: begin
        if (fault_clr) begin
          fault_code_next = 2'd0;
          state_next      = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase

    if (retire) state_next = run ? S_IF1 : S_IDLE;
  end

endmodule
